bt_servo_cmd_tx: RTL and testbench

Host-side initiator for the HC-05 servo command protocol. Accepts a binary command request, formats it as ASCII ("A<deg>\n", "P<us>\n", or single-letter L/R/X/T/I), and streams the bytes to a uart_tx byte interface. It then waits for the servo controller's acknowledge byte on a uart_rx byte interface, retries on timeout, and reports completion status. It sits between control logic (sweep sequencer, button decoder) and the UART pair driving the Bluetooth link.

---
 rtl/bt_servo_cmd_tx.sv | 230 +++++++++++++++++++++++
 tb/tb_bt_servo_cmd_tx.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bt_servo_cmd_tx.sv
// Host-side HC-05 servo command initiator: formats a binary request as ASCII, streams it to uart_tx,
// then waits for the ack byte with timeout/retry. Optional macro BT_SERVO_CMD_CLAMP_EN clamps cmd_val.
`timescale 1ns/1ps
module bt_servo_cmd_tx #(
  parameter int CLK_FREQ        = 50_000_000,
  parameter int ACK_TIMEOUT_CYC = CLK_FREQ / 10,
  parameter int MAX_RETRY       = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [15:0] cmd_val,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  input  logic        tx_busy,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        done,
  output logic [1:0]  status,
  output logic        busy,
  output logic [2:0]  dbg_state
);

  // Handshake: a command is taken on any cycle where cmd_valid && cmd_ready; cmd_ready is high only in IDLE.
  localparam int TW = $clog2(ACK_TIMEOUT_CYC + 1);
  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CONV, S_SEND, S_WAIT_TX, S_WAIT_ACK, S_DONE
  } state_t;

  state_t          state;
  logic [2:0]      op_q;
  logic [15:0]     rem;
  logic [2:0]      conv_pos;
  logic [3:0]      conv_cnt;
  logic [4:0][3:0] digs;
  logic [2:0]      ndig;
  logic [2:0]      idx;
  logic            guard;
  logic            ack_open;
  logic [TW-1:0]   tmo_cnt;
  logic [RW-1:0]   retry_cnt;

  logic            is_ap;
  logic [15:0]     pow;
  logic [15:0]     val_in;
  logic [7:0]      cur_byte;
  logic            cur_last;
  logic [7:0]      ack_byte;
  logic            ack_hit;
  logic            tmo_end;

  assign dbg_state = state;
  assign is_ap     = (op_q == 3'd0) || (op_q == 3'd1);
  assign ack_byte  = is_ap ? 8'h4B : 8'h4F;
  assign ack_hit   = ack_open && rx_valid && (rx_data == ack_byte);
  assign tmo_end   = (tmo_cnt == TW'(ACK_TIMEOUT_CYC - 1));

  always_comb begin
    val_in = cmd_val;
`ifdef BT_SERVO_CMD_CLAMP_EN
    if (cmd_op == 3'd0 && cmd_val > 16'd270) val_in = 16'd270;
    if (cmd_op == 3'd1 && cmd_val < 16'd500) val_in = 16'd500;
    if (cmd_op == 3'd1 && cmd_val > 16'd2500) val_in = 16'd2500;
`endif
  end

  always_comb begin
    case (conv_pos)
      3'd0:    pow = 16'd10000;
      3'd1:    pow = 16'd1000;
      3'd2:    pow = 16'd100;
      3'd3:    pow = 16'd10;
      default: pow = 16'd1;
    endcase
  end

  // Frame layout: index 0 is the letter, then ndig digits, then '\n' (A/P only).
  always_comb begin
    cur_byte = 8'h00;
    cur_last = 1'b0;
    if (idx == 3'd0) begin
      case (op_q)
        3'd0:    cur_byte = 8'h41;
        3'd1:    cur_byte = 8'h50;
        3'd2:    cur_byte = 8'h4C;
        3'd3:    cur_byte = 8'h52;
        3'd4:    cur_byte = 8'h58;
        3'd5:    cur_byte = 8'h54;
        default: cur_byte = 8'h49;
      endcase
      cur_last = !is_ap;
    end else if (idx <= ndig) begin
      cur_byte = 8'h30 | {4'h0, digs[idx - 3'd1]};
    end else begin
      cur_byte = 8'h0A;
      cur_last = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      op_q      <= '0;
      rem       <= '0;
      conv_pos  <= '0;
      conv_cnt  <= '0;
      digs      <= '0;
      ndig      <= '0;
      idx       <= '0;
      guard     <= 1'b0;
      ack_open  <= 1'b0;
      tmo_cnt   <= '0;
      retry_cnt <= '0;
      cmd_ready <= 1'b1;
      tx_data   <= '0;
      tx_start  <= 1'b0;
      done      <= 1'b0;
      status    <= '0;
      busy      <= 1'b0;
    end else begin
      tx_start <= 1'b0;
      done     <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            op_q      <= cmd_op;
            rem       <= val_in;
            conv_pos  <= '0;
            conv_cnt  <= '0;
            digs      <= '0;
            ndig      <= '0;
            idx       <= '0;
            retry_cnt <= '0;
            ack_open  <= 1'b0;
            tmo_cnt   <= '0;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            if (cmd_op == 3'd7) begin
              done   <= 1'b1;
              status <= 2'd2;
              state  <= S_DONE;
            end else if (cmd_op <= 3'd1) begin
              state <= S_CONV;
            end else begin
              state <= S_SEND;
            end
          end
        end
        S_CONV: begin
          // One subtraction per cycle; a place value is emitted once any nonzero digit has been seen.
          if (conv_pos == 3'd4) begin
            digs[ndig] <= rem[3:0];
            ndig       <= ndig + 3'd1;
            state      <= S_SEND;
          end else if (rem >= pow) begin
            rem      <= rem - pow;
            conv_cnt <= conv_cnt + 4'd1;
          end else begin
            if (conv_cnt != 4'd0 || ndig != 3'd0) begin
              digs[ndig] <= conv_cnt;
              ndig       <= ndig + 3'd1;
            end
            conv_cnt <= '0;
            conv_pos <= conv_pos + 3'd1;
          end
        end
        S_SEND: begin
          if (!tx_busy) begin
            tx_data  <= cur_byte;
            tx_start <= 1'b1;
            guard    <= 1'b1;
            state    <= S_WAIT_TX;
            if (cur_last) begin
              ack_open <= 1'b1;
              tmo_cnt  <= '0;
            end
          end
        end
        S_WAIT_TX: begin
          if (guard) begin
            guard <= 1'b0;
          end else if (!tx_busy) begin
            if (ack_open) begin
              state <= S_WAIT_ACK;
            end else begin
              idx   <= idx + 3'd1;
              state <= S_SEND;
            end
          end
        end
        S_WAIT_ACK: ;
        S_DONE: begin
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      // Ack window runs from the final byte's tx_start; an ack on the last counted cycle beats the timeout.
      if (ack_open) begin
        if (ack_hit) begin
          ack_open <= 1'b0;
          done     <= 1'b1;
          status   <= 2'd0;
          state    <= S_DONE;
        end else if (tmo_end) begin
          ack_open <= 1'b0;
          guard    <= 1'b0;
          if (retry_cnt < RW'(MAX_RETRY)) begin
            retry_cnt <= retry_cnt + 1'b1;
            idx       <= '0;
            state     <= S_SEND;
          end else begin
            done   <= 1'b1;
            status <= 2'd1;
            state  <= S_DONE;
          end
        end else begin
          tmo_cnt <= tmo_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_bt_servo_cmd_tx.sv
// Directed bench for bt_servo_cmd_tx: uart_tx byte model, ack injection, frame scoreboard, timeout and reset cases.
`timescale 1ns/1ps
module tb_bt_servo_cmd_tx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_op = '0;
  logic [15:0] cmd_val = '0;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        done;
  logic [1:0]  status;
  logic        busy;
  logic [2:0]  dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int busy_cnt = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  logic [1:0] done_status = '0;
  int d_base = 0;
  int drive_cyc = 0;

  logic [7:0] exp_q[$];
  logic [7:0] cap_q[$];
  int         start_cyc_q[$];

  bt_servo_cmd_tx #(
    .CLK_FREQ(50_000_000),
    .ACK_TIMEOUT_CYC(1000),
    .MAX_RETRY(2)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_val(cmd_val),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
    .rx_valid(rx_valid), .rx_data(rx_data),
    .done(done), .status(status), .busy(busy), .dbg_state(dbg_state)
  );

  // Clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // uart_tx model: captures each started byte and stays busy for 20 cycles.
  always @(negedge clk) begin
    if (tx_start) begin
      cap_q.push_back(tx_data);
      start_cyc_q.push_back(cyc);
      busy_cnt = 20;
    end else if (busy_cnt > 0) begin
      busy_cnt--;
    end
    tx_busy = (busy_cnt != 0);
  end

  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      done_status = status;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic issue(input logic [2:0] op, input logic [15:0] v);
    int k;
    k = 0;
    @(negedge clk);
    while (!cmd_ready && k < 2000) begin
      @(negedge clk);
      k++;
    end
    d_base    = done_cnt;
    drive_cyc = cyc;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_val   = v;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_bytes(input int n, input int budget, output bit ok);
    int k;
    k = 0;
    while (!(cap_q.size() >= n && !tx_busy) && k < budget) begin
      @(negedge clk);
      k++;
    end
    ok = (cap_q.size() >= n && !tx_busy);
  endtask

  task automatic send_rx(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic finish_cmd(input string tag, input logic [1:0] exp_status, input int budget);
    int k;
    bit ok;
    k = 0;
    while (done_cnt == d_base && k < budget) begin
      @(negedge clk);
      k++;
    end
    ok = (done_cnt != d_base);
    check({tag, "_done_seen"}, 32'(ok), 32'd1);
    check({tag, "_status"}, 32'(done_status), 32'(exp_status));
    tick(3);
    check({tag, "_one_done"}, done_cnt - d_base, 32'd1);
    check({tag, "_ready_back"}, {busy, cmd_ready}, 32'b01);
  endtask

  task automatic check_frame(input string tag);
    check({tag, "_len"}, cap_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++)
      check($sformatf("%s_b%0d", tag, i), 32'(cap_q[i]), 32'(exp_q[i]));
    cap_q.delete();
    exp_q.delete();
    start_cyc_q.delete();
  endtask

  initial begin
    bit ok;
    int c0;

    // Reset state
    tick(3);
    check("rst_ready", 32'(cmd_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_tx_start", 32'(tx_start), 32'd0);
    check("rst_status", 32'(status), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    rst_n = 1'b1;
    tick(2);

    // A135 acked with 'K'
    issue(3'd0, 16'd135);
    wait_bytes(5, 3000, ok);
    check("a135_frame_seen", 32'(ok), 32'd1);
    tick(50);
    send_rx(8'h4B);
    finish_cmd("a135", 2'd0, 200);
    exp_q = '{8'h41, 8'h31, 8'h33, 8'h35, 8'h0A};
    check_frame("a135");

    // P0 and P2500
    issue(3'd1, 16'd0);
    wait_bytes(3, 3000, ok);
    tick(10);
    send_rx(8'h4B);
    finish_cmd("p0", 2'd0, 200);
    exp_q = '{8'h50, 8'h30, 8'h0A};
    check_frame("p0");

    issue(3'd1, 16'd2500);
    wait_bytes(6, 3000, ok);
    tick(10);
    send_rx(8'h4B);
    finish_cmd("p2500", 2'd0, 200);
    exp_q = '{8'h50, 8'h32, 8'h35, 8'h30, 8'h30, 8'h0A};
    check_frame("p2500");

    // L: 'K' is the wrong ack for a single-letter op, 'O' completes it
    issue(3'd2, 16'd999);
    wait_bytes(1, 3000, ok);
    tick(10);
    send_rx(8'h4B);
    tick(20);
    check("l_k_ignored", done_cnt - d_base, 32'd0);
    send_rx(8'h4F);
    finish_cmd("l", 2'd0, 200);
    exp_q = '{8'h4C};
    check_frame("l");

    // X with no responder: three attempts, then timeout status
    issue(3'd4, 16'd0);
    finish_cmd("x", 2'd1, 5000);
    check("x_attempts", start_cyc_q.size(), 32'd3);
    if (start_cyc_q.size() == 3) begin
      check("x_gap1_ok", 32'((start_cyc_q[1] - start_cyc_q[0]) inside {[1000:1005]}), 32'd1);
      check("x_gap2_ok", 32'((start_cyc_q[2] - start_cyc_q[1]) inside {[1000:1005]}), 32'd1);
      check("x_done_lat", done_cyc - start_cyc_q[2], 32'd1000);
    end
    exp_q = '{8'h58, 8'h58, 8'h58};
    check_frame("x");

    // I: ack arrives on the last counted cycle of the window and must win
    issue(3'd6, 16'd0);
    wait_bytes(1, 3000, ok);
    c0 = (start_cyc_q.size() > 0) ? start_cyc_q[0] : cyc;
    while (cyc < c0 + 999) @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = 8'h4F;
    @(negedge clk);
    rx_valid = 1'b0;
    finish_cmd("i_edge", 2'd0, 200);
    exp_q = '{8'h49};
    check_frame("i_edge");

    // A99 with a 'K' injected before the final byte
    issue(3'd0, 16'd99);
    c0 = 0;
    while (cap_q.size() < 1 && c0 < 3000) begin
      @(negedge clk);
      c0++;
    end
    send_rx(8'h4B);
    wait_bytes(4, 3000, ok);
    tick(30);
    check("a99_early_k_ignored", done_cnt - d_base, 32'd0);
    send_rx(8'h4B);
    finish_cmd("a99", 2'd0, 200);
    exp_q = '{8'h41, 8'h39, 8'h39, 8'h0A};
    check_frame("a99");

    // Reserved op
    issue(3'd7, 16'd5);
    finish_cmd("op7", 2'd2, 50);
    check("op7_latency", done_cyc - drive_cyc, 32'd1);
    check("op7_no_bytes", cap_q.size(), 32'd0);
    check_frame("op7");

    // cmd_valid held while busy is dropped
    issue(3'd5, 16'd0);
    cmd_valid = 1'b1;
    cmd_op    = 3'd7;
    tick(10);
    cmd_valid = 1'b0;
    wait_bytes(1, 3000, ok);
    tick(10);
    send_rx(8'h4F);
    finish_cmd("t_busy_ign", 2'd0, 200);
    exp_q = '{8'h54};
    check_frame("t_busy_ign");

    // A270 interrupted by reset after two bytes
    issue(3'd0, 16'd270);
    c0 = 0;
    while (cap_q.size() < 2 && c0 < 3000) begin
      @(negedge clk);
      c0++;
    end
    rst_n = 1'b0;
    #1;
    check("rstmid_tx_start", 32'(tx_start), 32'd0);
    check("rstmid_ready", 32'(cmd_ready), 32'd1);
    check("rstmid_busy", 32'(busy), 32'd0);
    tick(3);
    rst_n = 1'b1;
    tick(300);
    check("rstmid_no_done", done_cnt - d_base, 32'd0);
    exp_q = '{8'h41, 8'h32};
    check_frame("rstmid");

    // A300 and A65535: clamped only when the clamp build is enabled
    issue(3'd0, 16'd300);
    wait_bytes(5, 3000, ok);
    tick(10);
    send_rx(8'h4B);
    finish_cmd("a300", 2'd0, 200);
`ifdef BT_SERVO_CMD_CLAMP_EN
    exp_q = '{8'h41, 8'h32, 8'h37, 8'h30, 8'h0A};
`else
    exp_q = '{8'h41, 8'h33, 8'h30, 8'h30, 8'h0A};
`endif
    check_frame("a300");

    issue(3'd0, 16'd65535);
`ifdef BT_SERVO_CMD_CLAMP_EN
    wait_bytes(5, 3000, ok);
`else
    wait_bytes(7, 3000, ok);
`endif
    tick(10);
    send_rx(8'h4B);
    finish_cmd("a65535", 2'd0, 200);
`ifdef BT_SERVO_CMD_CLAMP_EN
    exp_q = '{8'h41, 8'h32, 8'h37, 8'h30, 8'h0A};
`else
    exp_q = '{8'h41, 8'h36, 8'h35, 8'h35, 8'h33, 8'h35, 8'h0A};
`endif
    check_frame("a65535");

    check("end_state_idle", 32'(dbg_state), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
